// File: rtl/tm_pkg.sv
// Shared types and width helpers for the Tsetlin-machine clause vote engine.
package tm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // Literal vector holds every feature and its complement.
    function automatic int lit_width(input int num_features);
        return 2 * num_features;
    endfunction

    // Signed sum must cover -NUM_CLAUSES/2 .. +NUM_CLAUSES/2.
    function automatic int sum_width(input int num_clauses);
        return $clog2(num_clauses + 1) + 1;
    endfunction

    // Even clause indices vote for the class, odd indices vote against it.
    function automatic int clause_polarity(input int unsigned idx);
        return (idx % 2 == 0) ? 1 : -1;
    endfunction

endpackage

// File: rtl/tm_clause_eval.sv
// Combinational evaluation of a single Tsetlin clause against a feature vector.
module tm_clause_eval
    import tm_pkg::*;
#(
    parameter int NUM_FEATURES     = 2,
    parameter int EMPTY_CLAUSE_ONE = 0,
    localparam int LW              = lit_width(NUM_FEATURES)
) (
    input  logic [NUM_FEATURES-1:0] features,
    input  logic [LW-1:0]           mask,
    output logic                    clause
);

    logic [LW-1:0] lit;

    // Literals are complements in the low half, plain features in the high half;
    // a fully excluded clause takes the configured empty-clause value.
    always_comb begin
        lit    = {features, ~features};
        clause = &(mask | lit);
        if (&mask) begin
            clause = (EMPTY_CLAUSE_ONE != 0);
        end
    end

endmodule

// File: rtl/tm_clause_vote_engine.sv
// Tsetlin-machine inference engine: evaluates one clause per cycle on a latched
// sample and accumulates polarity votes into a signed class sum.
module tm_clause_vote_engine
    import tm_pkg::*;
#(
    parameter int NUM_FEATURES     = 2,
    parameter int NUM_CLAUSES      = 4,
    parameter int EMPTY_CLAUSE_ONE = 0,
    localparam int LW              = lit_width(NUM_FEATURES),
    localparam int SW              = sum_width(NUM_CLAUSES),
    localparam int CW              = $clog2(NUM_CLAUSES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [CW-1:0]           cfg_addr,
    input  logic [LW-1:0]           cfg_data,
    output logic                    cfg_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_FEATURES-1:0] in_features,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [SW-1:0]    out_sum,
    output logic                    out_pred,
    output logic [NUM_CLAUSES-1:0]  out_clauses
);

    state_t                  state;
    logic [LW-1:0]           masks [NUM_CLAUSES];
    logic [NUM_FEATURES-1:0] feat;
    logic [CW-1:0]           cnt;
    logic                    clause_bit;
    logic signed [SW-1:0]    sum_next;

    assign cfg_ready = (state == IDLE);
    assign in_ready  = (state == IDLE);

    tm_clause_eval #(
        .NUM_FEATURES    (NUM_FEATURES),
        .EMPTY_CLAUSE_ONE(EMPTY_CLAUSE_ONE)
    ) u_clause_eval (
        .features(feat),
        .mask    (masks[cnt]),
        .clause  (clause_bit)
    );

    // Running sum after applying the current clause's vote.
    always_comb begin
        sum_next = out_sum + SW'(clause_polarity(32'(cnt)));
    end

    // Mask store, sample latch and IDLE/EVAL/DONE sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
                masks[i] <= '1;
            end
            feat        <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_pred    <= 1'b0;
            out_clauses <= '0;
        end else begin
            if (state == IDLE && cfg_we && 32'(cfg_addr) < NUM_CLAUSES) begin
                masks[cfg_addr] <= cfg_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat        <= in_features;
                        cnt         <= '0;
                        out_sum     <= '0;
                        out_pred    <= 1'b1;
                        out_clauses <= '0;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    out_clauses[cnt] <= clause_bit;
                    if (clause_bit) begin
                        out_sum  <= sum_next;
                        out_pred <= ~sum_next[SW-1];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NUM_CLAUSES - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
